// File: rtl/csa_final_adder_pipe.sv
// csa_final_adder_pipe: two-stage split carry-propagate adder resolving a carry-save pair into prod;
// define CSA_FINAL_ADDER_STICKY_EN to add the out_sticky output.
module csa_final_adder_pipe #(
   parameter int WIDTH      = 14,
   parameter int SPLIT      = 7,
   parameter int STICKY_LSB = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] pp0,
   input  logic [WIDTH-1:0] pp1,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] prod
`ifdef CSA_FINAL_ADDER_STICKY_EN
   ,
   output logic             out_sticky
`endif
);
   localparam int HW = WIDTH - SPLIT;

   if (SPLIT < 1 || SPLIT > WIDTH - 1 || STICKY_LSB < 1 || STICKY_LSB > SPLIT) begin : g_bad_params
      $error("csa_final_adder_pipe: illegal SPLIT/STICKY_LSB");
   end

   logic             v1, v2, rdy1, rdy2, ld1, ld2, c1;
   logic [SPLIT:0]   lo_full;
   logic [SPLIT-1:0] lo_sum;
   logic [HW-1:0]    hi0, hi1, hi_sum;

   // Handshake readies, load enables and the two partial adds.
   always_comb begin
      rdy2    = !v2 || out_ready;
      rdy1    = !v1 || rdy2;
      ld1     = in_valid && rdy1;
      ld2     = v1 && rdy2;
      lo_full = {1'b0, pp0[SPLIT-1:0]} + {1'b0, pp1[SPLIT-1:0]};
      hi_sum  = hi0 + hi1 + HW'(c1);
   end

   assign in_ready  = rdy1;
   assign out_valid = v2;

   // Stage occupancy: a load always wins over a drain of the same stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1 <= 1'b0;
         v2 <= 1'b0;
      end else begin
         v1 <= ld1 ? 1'b1 : (ld2 ? 1'b0 : v1);
         v2 <= ld2 ? 1'b1 : (out_ready ? 1'b0 : v2);
      end
   end

   // Stage 1 data: low sum with its carry, plus the untouched high halves.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lo_sum <= '0;
         c1     <= 1'b0;
         hi0    <= '0;
         hi1    <= '0;
      end else if (ld1) begin
         lo_sum <= lo_full[SPLIT-1:0];
         c1     <= lo_full[SPLIT];
         hi0    <= pp0[WIDTH-1:SPLIT];
         hi1    <= pp1[WIDTH-1:SPLIT];
      end
   end

   // Stage 2 data: finish the high half and hold the result until it is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prod <= '0;
      else if (ld2) prod <= {hi_sum, lo_sum};
   end

`ifdef CSA_FINAL_ADDER_STICKY_EN
   logic s1;

   // Sticky bit travels alongside the data of each stage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1         <= 1'b0;
         out_sticky <= 1'b0;
      end else begin
         if (ld1) s1 <= |lo_full[STICKY_LSB-1:0];
         if (ld2) out_sticky <= s1;
      end
   end
`endif

endmodule

// File: tb/tb_csa_final_adder_pipe.sv
// tb_csa_final_adder_pipe: random and directed stimulus checked against a queue-based timing/value model.
module tb_csa_final_adder_pipe;
   localparam int W = 14;
   localparam int SL = 4;

   logic         clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [W-1:0] pp0 = '0, pp1 = '0;
   logic         in_ready, out_valid;
   logic [W-1:0] prod;
`ifdef CSA_FINAL_ADDER_STICKY_EN
   logic         out_sticky;
`endif

   csa_final_adder_pipe dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .pp0(pp0), .pp1(pp1), .out_valid(out_valid), .out_ready(out_ready), .prod(prod)
`ifdef CSA_FINAL_ADDER_STICKY_EN
      , .out_sticky(out_sticky)
`endif
   );

   always #5 clk = ~clk;

   typedef struct { logic [W-1:0] val; int t; } item_t;
   item_t q[$];
   int cyc = 0, checks = 0, errors = 0;
   logic s_ir, s_ov;
   logic [W-1:0] s_prod;

   task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // One clock cycle: drive inputs, compare against the model, then advance the model.
   task automatic step(input logic iv, input logic [W-1:0] a, input logic [W-1:0] b, input logic ordy);
      logic exp_ir, exp_ov;
      item_t it;
      @(negedge clk);
      in_valid = iv; pp0 = a; pp1 = b; out_ready = ordy;
      #1;
      s_ir = in_ready; s_ov = out_valid; s_prod = prod;
      exp_ir = (q.size() < 2) || ordy;
      exp_ov = (q.size() > 0) && (q[0].t <= cyc);
      chk("in_ready", W'(in_ready), W'(exp_ir));
      chk("out_valid", W'(out_valid), W'(exp_ov));
      if (exp_ov) begin
         chk("prod", prod, q[0].val);
`ifdef CSA_FINAL_ADDER_STICKY_EN
         chk("out_sticky", W'(out_sticky), W'(|q[0].val[SL-1:0]));
`endif
      end
      if (exp_ov && ordy) begin
         void'(q.pop_front());
         if (q.size() > 0 && q[0].t < cyc + 1) q[0].t = cyc + 1;
      end
      if (iv && exp_ir) begin
         it.val = a + b;
         it.t = cyc + 2;
         q.push_back(it);
      end
      cyc++;
   endtask

   initial begin
      #1;
      chk("reset out_valid", W'(out_valid), '0);
      chk("reset prod", prod, '0);
`ifdef CSA_FINAL_ADDER_STICKY_EN
      chk("reset out_sticky", W'(out_sticky), '0);
`endif
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;

      // Basic add, 127*127 in carry-save form.
      step(1, 14'h3F00, 14'h0001, 1);
      step(0, '0, '0, 1);
      step(0, '0, '0, 1);
      chk("basic valid", W'(s_ov), W'(1'b1));
      chk("basic prod", s_prod, 14'h3F01);
`ifdef CSA_FINAL_ADDER_STICKY_EN
      chk("basic sticky", W'(out_sticky), W'(1'b1));
`endif
      step(0, '0, '0, 1);
      chk("basic single pulse", W'(s_ov), W'(1'b0));

      // Carry across the split.
      step(1, 14'h007F, 14'h0001, 1);
      step(0, '0, '0, 1);
      step(0, '0, '0, 1);
      chk("split carry prod", s_prod, 14'h0080);
`ifdef CSA_FINAL_ADDER_STICKY_EN
      chk("split carry sticky", W'(out_sticky), W'(1'b0));
`endif

      // Wrap-around drops the carry out.
      step(1, 14'h3FFF, 14'h0001, 1);
      step(0, '0, '0, 1);
      step(0, '0, '0, 1);
      chk("wrap valid", W'(s_ov), W'(1'b1));
      chk("wrap prod", s_prod, 14'h0000);

      // Streaming: 8 back-to-back pairs.
      for (int i = 0; i < 8; i++) begin
         step(1, W'(i * 3), W'(100), 1);
         chk("stream in_ready", W'(s_ir), W'(1'b1));
      end
      for (int i = 0; i < 3; i++) step(0, '0, '0, 1);

      // Backpressure: two accepted, third stalled, then released.
      step(1, 14'h0100, 14'h0011, 0);
      step(1, 14'h0200, 14'h0022, 0);
      step(1, 14'h0300, 14'h0033, 0);
      chk("bp third stalled", W'(s_ir), W'(1'b0));
      chk("bp first held", s_prod, 14'h0111);
      step(1, 14'h0300, 14'h0033, 0);
      chk("bp still held", s_prod, 14'h0111);
      step(1, 14'h0300, 14'h0033, 1);
      chk("bp release accept", W'(s_ir), W'(1'b1));
      for (int i = 0; i < 4; i++) step(0, '0, '0, 1);

      // Reset mid-flight discards both in-flight items.
      step(1, 14'h0AAA, 14'h0111, 1);
      step(1, 14'h0555, 14'h0222, 1);
      #3 rst_n = 1'b0;
      #1;
      chk("async rst out_valid", W'(out_valid), '0);
      chk("async rst prod", prod, '0);
      q.delete();
      @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      cyc++;
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) step(0, '0, '0, 1);

      // Random traffic with random backpressure.
      for (int i = 0; i < 3000; i++)
         step(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom), 1'($urandom_range(0, 2) != 0));
      for (int i = 0; i < 5; i++) step(0, '0, '0, 1);
      chk("drained", W'(q.size()), '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
